// File: rtl/rsa_job_sequencer_if.sv
`default_nettype none
// ==========================================================================
// rsa_job_sequencer_if : word-in, core and word-out handshakes of the sequencer
// Revision: 1.0
// ==========================================================================
interface rsa_job_sequencer_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic [N-1:0] in_word;
   logic         core_start;
   logic [N-1:0] core_modulus;
   logic [N-1:0] core_exponent;
   logic [N-1:0] core_base;
   logic         core_done;
   logic [N-1:0] core_result;
   logic         out_valid;
   logic [N-1:0] out_word;
   logic         out_busy;
   logic         busy;
   logic         overrun;
   logic         timeout;
   logic         bad_mod;

   modport master (
      input  in_valid, in_word, core_done, core_result, out_busy,
      output core_start, core_modulus, core_exponent, core_base,
             out_valid, out_word, busy, overrun, timeout, bad_mod
   );

   modport slave (
      output in_valid, in_word, core_done, core_result, out_busy,
      input  core_start, core_modulus, core_exponent, core_base,
             out_valid, out_word, busy, overrun, timeout, bad_mod
   );
endinterface
`default_nettype wire

// File: rtl/rsa_job_sequencer.sv
`default_nettype none
// ==========================================================================
// rsa_job_sequencer : collects modulus/exponent/base, runs the core, sends result
// Revision: 1.0
// ==========================================================================
module rsa_job_sequencer #(
   parameter int N    = 32,
   parameter int TO_W = 24
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   rsa_job_sequencer_if.master  bus
);
   localparam logic [2:0] S_LOAD_MOD     = 3'd0;
   localparam logic [2:0] S_LOAD_EXP     = 3'd1;
   localparam logic [2:0] S_LOAD_BASE    = 3'd2;
   localparam logic [2:0] S_START        = 3'd3;
   localparam logic [2:0] S_WAIT_CORE    = 3'd4;
   localparam logic [2:0] S_SEND         = 3'd5;
   localparam logic [2:0] S_WAIT_TX_ACK  = 3'd6;
   localparam logic [2:0] S_WAIT_TX_DONE = 3'd7;

   logic [2:0]      r_state;
   logic [2:0]      w_next;
   logic [TO_W-1:0] r_wd;
   logic            w_wd_exp;
   logic            w_waiting;
   logic [N-1:0]    r_mod;
   logic [N-1:0]    r_exp;
   logic [N-1:0]    r_base;
   logic [N-1:0]    r_out_word;
   logic            r_core_start;
   logic            r_overrun;
   logic            r_timeout;
   logic            r_bad_mod;
   logic            w_busy;
   logic            w_out_valid;

   assign w_wd_exp  = &r_wd;
   assign w_waiting = (r_state == S_WAIT_CORE) || (r_state == S_WAIT_TX_ACK) ||
                      (r_state == S_WAIT_TX_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_LOAD_MOD;
      else        r_state <= w_next;
   end

   // core_done takes priority over watchdog expiry; out_busy over expiry in WAIT_TX_ACK
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD_MOD:     if (bus.in_valid) w_next = S_LOAD_EXP;
         S_LOAD_EXP:     if (bus.in_valid) w_next = S_LOAD_BASE;
         S_LOAD_BASE:    if (bus.in_valid) w_next = (r_mod == '0) ? S_SEND : S_START;
         S_START:        w_next = S_WAIT_CORE;
         S_WAIT_CORE:    if (bus.core_done || w_wd_exp) w_next = S_SEND;
         S_SEND:         w_next = S_WAIT_TX_ACK;
         S_WAIT_TX_ACK: begin
            if (bus.out_busy)   w_next = S_WAIT_TX_DONE;
            else if (w_wd_exp)  w_next = S_LOAD_MOD;
         end
         S_WAIT_TX_DONE: if (!bus.out_busy || w_wd_exp) w_next = S_LOAD_MOD;
         default:        w_next = S_LOAD_MOD;
      endcase
   end

   always_comb begin
      w_busy      = 1'b1;
      w_out_valid = 1'b0;
      case (r_state)
         S_LOAD_MOD, S_LOAD_EXP, S_LOAD_BASE: w_busy = 1'b0;
         S_SEND:                              w_out_valid = 1'b1;
         default:                             w_busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wd         <= '0;
         r_mod        <= '0;
         r_exp        <= '0;
         r_base       <= '0;
         r_out_word   <= '0;
         r_core_start <= 1'b0;
         r_overrun    <= 1'b0;
         r_timeout    <= 1'b0;
         r_bad_mod    <= 1'b0;
      end else begin
         // registered from START so the pulse lands two cycles after the base word
         r_core_start <= (r_state == S_START);

         if (w_next != r_state)        r_wd <= '0;
         else if (w_waiting && !w_wd_exp) r_wd <= r_wd + 1'b1;

         if (bus.in_valid && w_busy) r_overrun <= 1'b1;

         case (r_state)
            S_LOAD_MOD:  if (bus.in_valid) r_mod <= bus.in_word;
            S_LOAD_EXP:  if (bus.in_valid) r_exp <= bus.in_word;
            S_LOAD_BASE: begin
               if (bus.in_valid) begin
                  r_base <= bus.in_word;
                  if (r_mod == '0) begin
                     r_bad_mod  <= 1'b1;
                     r_out_word <= '0;
                  end
               end
            end
            S_WAIT_CORE: begin
               if (bus.core_done) begin
                  r_out_word <= bus.core_result;
               end else if (w_wd_exp) begin
                  r_timeout  <= 1'b1;
                  r_out_word <= '1;
               end
            end
            S_WAIT_TX_ACK:  if (!bus.out_busy && w_wd_exp) r_timeout <= 1'b1;
            S_WAIT_TX_DONE: if (bus.out_busy && w_wd_exp)  r_timeout <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.core_start    = r_core_start;
   assign bus.core_modulus  = r_mod;
   assign bus.core_exponent = r_exp;
   assign bus.core_base     = r_base;
   assign bus.out_valid     = w_out_valid;
   assign bus.out_word      = r_out_word;
   assign bus.busy          = w_busy;
   assign bus.overrun       = r_overrun;
   assign bus.timeout       = r_timeout;
   assign bus.bad_mod       = r_bad_mod;
endmodule
`default_nettype wire

// File: tb/tb_rsa_job_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_rsa_job_sequencer : directed bench; dut_a uses TO_W=24, dut_b uses TO_W=4
// Revision: 1.0
// ==========================================================================
module tb_rsa_job_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        use_b = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_word = '0;
   logic        core_done = 1'b0;
   logic [31:0] core_result = '0;
   logic        out_busy = 1'b0;
   int          checks = 0;
   int          errors = 0;

   rsa_job_sequencer_if #(.N(32)) ia ();
   rsa_job_sequencer_if #(.N(32)) ib ();

   rsa_job_sequencer #(.N(32), .TO_W(24)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   rsa_job_sequencer #(.N(32), .TO_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   always #5 clk = ~clk;

   assign ia.in_valid    = in_valid & ~use_b;
   assign ia.in_word     = in_word;
   assign ia.core_done   = core_done & ~use_b;
   assign ia.core_result = core_result;
   assign ia.out_busy    = out_busy & ~use_b;
   assign ib.in_valid    = in_valid & use_b;
   assign ib.in_word     = in_word;
   assign ib.core_done   = core_done & use_b;
   assign ib.core_result = core_result;
   assign ib.out_busy    = out_busy & use_b;

   logic        s_core_start, s_out_valid, s_busy, s_overrun, s_timeout, s_bad_mod;
   logic [31:0] s_mod, s_exp, s_base, s_out_word;
   assign s_core_start = use_b ? ib.core_start    : ia.core_start;
   assign s_out_valid  = use_b ? ib.out_valid     : ia.out_valid;
   assign s_busy       = use_b ? ib.busy          : ia.busy;
   assign s_overrun    = use_b ? ib.overrun       : ia.overrun;
   assign s_timeout    = use_b ? ib.timeout       : ia.timeout;
   assign s_bad_mod    = use_b ? ib.bad_mod       : ia.bad_mod;
   assign s_mod        = use_b ? ib.core_modulus  : ia.core_modulus;
   assign s_exp        = use_b ? ib.core_exponent : ia.core_exponent;
   assign s_base       = use_b ? ib.core_base     : ia.core_base;
   assign s_out_word   = use_b ? ib.out_word      : ia.out_word;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      in_valid = 1'b1;
      in_word  = w;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic load_job(input logic [31:0] m, input logic [31:0] e, input logic [31:0] b);
      send_word(m);
      send_word(e);
      send_word(b);
   endtask

   task automatic pulse_done(input logic [31:0] r);
      core_done   = 1'b1;
      core_result = r;
      @(negedge clk);
      core_done   = 1'b0;
   endtask

   // Called on the cycle out_valid is seen; models a short UART transmission.
   task automatic do_tx();
      step(1);
      out_busy = 1'b1;
      step(3);
      out_busy = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         use_b = (d == 1);
         #1;
         checks++;
         if ({s_core_start, s_out_valid, s_busy, s_overrun, s_timeout, s_bad_mod} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags dut%0d: got %b want 000000", d,
                     {s_core_start, s_out_valid, s_busy, s_overrun, s_timeout, s_bad_mod});
         end
         checks++;
         if ({s_mod, s_exp, s_base, s_out_word} !== 128'h0) begin
            errors++;
            $display("FAIL reset_regs dut%0d: got %h want 0", d, {s_mod, s_exp, s_base, s_out_word});
         end
      end
      use_b = 1'b0;
   endtask

   task automatic test_basic_job();
      load_job(32'h21, 32'h07, 32'h02);
      checks++;
      if (s_core_start !== 1'b0 || s_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_start_early: start=%b busy=%b want 0 1", s_core_start, s_busy);
      end
      step(1);
      checks++;
      if (s_core_start !== 1'b1) begin
         errors++;
         $display("FAIL basic_start: got %b want 1", s_core_start);
      end
      checks++;
      if ({s_mod, s_exp, s_base} !== {32'h21, 32'h07, 32'h02}) begin
         errors++;
         $display("FAIL basic_operands: got %h %h %h want 21 07 02", s_mod, s_exp, s_base);
      end
      step(1);
      checks++;
      if (s_core_start !== 1'b0) begin
         errors++;
         $display("FAIL basic_start_width: got %b want 0", s_core_start);
      end
      step(98);
      pulse_done(32'h1D);
      checks++;
      if (s_out_valid !== 1'b1 || s_out_word !== 32'h1D) begin
         errors++;
         $display("FAIL basic_result: valid=%b word=%h want 1 0000001d", s_out_valid, s_out_word);
      end
      step(1);
      out_busy = 1'b1;
      checks++;
      if (s_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_valid_width: got %b want 0", s_out_valid);
      end
      step(3);
      checks++;
      if (s_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_tx: got %b want 1", s_busy);
      end
      out_busy = 1'b0;
      step(1);
      checks++;
      if (s_busy !== 1'b0 || s_timeout !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: busy=%b timeout=%b want 0 0", s_busy, s_timeout);
      end
   endtask

   task automatic test_bad_modulus();
      int starts;
      load_job(32'h0, 32'h05, 32'h03);
      starts = s_core_start ? 1 : 0;
      checks++;
      if (s_out_valid !== 1'b1 || s_out_word !== 32'h0 || s_bad_mod !== 1'b1) begin
         errors++;
         $display("FAIL badmod_send: valid=%b word=%h bad=%b want 1 0 1",
                  s_out_valid, s_out_word, s_bad_mod);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 1) out_busy = 1'b1;
         if (i == 4) out_busy = 1'b0;
         step(1);
         if (s_core_start) starts++;
      end
      checks++;
      if (starts != 0 || s_busy !== 1'b0) begin
         errors++;
         $display("FAIL badmod_nostart: starts=%0d busy=%b want 0 0", starts, s_busy);
      end
   endtask

   task automatic test_overrun();
      checks++;
      if (s_overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_pre: got %b want 0", s_overrun);
      end
      load_job(32'h21, 32'h07, 32'h03);
      step(4);
      send_word(32'hDEADBEEF);
      checks++;
      if (s_overrun !== 1'b1 || s_busy !== 1'b1) begin
         errors++;
         $display("FAIL overrun_flag: ovr=%b busy=%b want 1 1", s_overrun, s_busy);
      end
      checks++;
      if ({s_mod, s_exp, s_base} !== {32'h21, 32'h07, 32'h03}) begin
         errors++;
         $display("FAIL overrun_operands: got %h %h %h want 21 07 03", s_mod, s_exp, s_base);
      end
      step(3);
      pulse_done(32'h09);
      checks++;
      if (s_out_valid !== 1'b1 || s_out_word !== 32'h09) begin
         errors++;
         $display("FAIL overrun_result: valid=%b word=%h want 1 00000009", s_out_valid, s_out_word);
      end
      do_tx();
   endtask

   task automatic test_reset_in_flight();
      int valids;
      load_job(32'h05, 32'h03, 32'h02);
      step(5);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      checks++;
      if ({s_busy, s_overrun, s_bad_mod, s_core_start} !== 4'b0 || s_mod !== 32'h0 ||
          s_out_word !== 32'h0) begin
         errors++;
         $display("FAIL midreset_state: flags=%b mod=%h word=%h want 0000 0 0",
                  {s_busy, s_overrun, s_bad_mod, s_core_start}, s_mod, s_out_word);
      end
      pulse_done(32'h03);
      valids = s_out_valid ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         step(1);
         if (s_out_valid) valids++;
      end
      checks++;
      if (valids != 0 || s_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_stale_done: valids=%0d busy=%b want 0 0", valids, s_busy);
      end
      load_job(32'h0B, 32'h0A, 32'h02);
      step(10);
      pulse_done(32'h01);
      checks++;
      if (s_out_valid !== 1'b1 || s_out_word !== 32'h01) begin
         errors++;
         $display("FAIL midreset_fresh: valid=%b word=%h want 1 00000001", s_out_valid, s_out_word);
      end
      do_tx();
      checks++;
      if (s_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idle: got %b want 0", s_busy);
      end
   endtask

   task automatic test_done_at_expiry();
      use_b = 1'b1;
      load_job(32'h03, 32'h02, 32'h02);
      step(1);
      step(15);
      checks++;
      if (s_timeout !== 1'b0 || s_out_valid !== 1'b0 || s_busy !== 1'b1) begin
         errors++;
         $display("FAIL tie_pre: timeout=%b valid=%b busy=%b want 0 0 1",
                  s_timeout, s_out_valid, s_busy);
      end
      pulse_done(32'h1234);
      checks++;
      if (s_out_valid !== 1'b1 || s_out_word !== 32'h1234 || s_timeout !== 1'b0) begin
         errors++;
         $display("FAIL tie_result: valid=%b word=%h timeout=%b want 1 00001234 0",
                  s_out_valid, s_out_word, s_timeout);
      end
      do_tx();
   endtask

   task automatic test_timeout();
      use_b = 1'b1;
      load_job(32'h03, 32'h02, 32'h02);
      step(1);
      step(15);
      checks++;
      if (s_timeout !== 1'b0 || s_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL to_early: timeout=%b valid=%b want 0 0", s_timeout, s_out_valid);
      end
      step(1);
      checks++;
      if (s_timeout !== 1'b1 || s_out_valid !== 1'b1 || s_out_word !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL to_expire: timeout=%b valid=%b word=%h want 1 1 ffffffff",
                  s_timeout, s_out_valid, s_out_word);
      end
      do_tx();
      load_job(32'h07, 32'h03, 32'h02);
      step(5);
      pulse_done(32'h01);
      checks++;
      if (s_out_valid !== 1'b1 || s_out_word !== 32'h01 || s_timeout !== 1'b1) begin
         errors++;
         $display("FAIL to_next_job: valid=%b word=%h timeout=%b want 1 00000001 1",
                  s_out_valid, s_out_word, s_timeout);
      end
      do_tx();
      checks++;
      if (s_busy !== 1'b0) begin
         errors++;
         $display("FAIL to_idle: got %b want 0", s_busy);
      end
      use_b = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic_job();
      test_bad_modulus();
      test_overrun();
      test_reset_in_flight();
      test_done_at_expiry();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/rsa_job_sequencer.md
Name: rsa_job_sequencer

Overview:
- Sits between the UART word-assembly path and the modular-exponentiation core.
- Collects three N-bit words from the serial-to-parallel assembler: modulus, exponent, base.
- Launches the core with those words, waits for its result, then hands the result word to the parallel-to-serial disassembler and waits until that transmission has finished.
- Rejects words that arrive while a job is in flight, and guards every wait with a watchdog so the top level cannot deadlock.

Parameters:
- N, 32, operand/result word width in bits
- TO_W, 24, watchdog counter width; a wait times out after 2^TO_W − 1 cycles

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- in_valid  in  1  one-cycle pulse: in_word holds a complete assembled word
- in_word  in  N  assembled word from serial_to_parallel
- core_start  out  1  one-cycle pulse that launches the core
- core_modulus  out  N  modulus operand, held stable from core_start until core_done
- core_exponent  out  N  exponent operand, held stable likewise
- core_base  out  N  base operand, held stable likewise
- core_done  in  1  one-cycle pulse from the core; core_result is valid in the same cycle
- core_result  in  N  core output
- out_valid  out  1  one-cycle pulse to parallel_to_serial
- out_word  out  N  word to transmit; stable from out_valid until the return to LOAD_MOD
- out_busy  in  1  high while parallel_to_serial/UART is sending
- busy  out  1  high in every state except LOAD_MOD/LOAD_EXP/LOAD_BASE
- overrun  out  1  sticky flag: an in_valid pulse arrived while busy
- timeout  out  1  sticky flag: the watchdog expired
- bad_mod  out  1  sticky flag: the received modulus was zero

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = LOAD_MOD
  - all outputs 0, all operand and out_word registers 0, watchdog counter 0
  - overrides any in-flight job; a core_done arriving later is ignored
- States: LOAD_MOD, LOAD_EXP, LOAD_BASE, START, WAIT_CORE, SEND, WAIT_TX_ACK, WAIT_TX_DONE.
- LOAD_MOD / LOAD_EXP / LOAD_BASE:
  - on in_valid, latch in_word into core_modulus / core_exponent / core_base respectively and advance one state
  - without in_valid, remain in the state
- LOAD_BASE exit:
  - if core_modulus == 0: set bad_mod, set out_word = 0, go to SEND (the core is not started)
  - otherwise go to START
- START: assert core_start for exactly 1 cycle, clear the watchdog, go to WAIT_CORE.
- WAIT_CORE:
  - on core_done: out_word <= core_result, go to SEND
  - if the watchdog reaches all-ones first: set timeout, out_word <= all-ones, go to SEND
  - core_done and watchdog expiry in the same cycle: core_done wins and timeout is not set
  - core_done outside WAIT_CORE is ignored
- SEND: out_valid = 1 for exactly 1 cycle, clear the watchdog, go to WAIT_TX_ACK.
- WAIT_TX_ACK:
  - when out_busy = 1, go to WAIT_TX_DONE
  - watchdog expiry: set timeout, go to LOAD_MOD
- WAIT_TX_DONE:
  - when out_busy = 0, go to LOAD_MOD
  - watchdog expiry: set timeout, go to LOAD_MOD
- Latency:
  - in_valid for the base word → core_start is 2 cycles later (LOAD_BASE → START registered)
  - core_done → out_valid is 1 cycle later
- Watchdog: increments every cycle in WAIT_CORE, WAIT_TX_ACK and WAIT_TX_DONE; saturates; cleared on entry to each of those states.
- An in_valid pulse while busy = 1: word dropped, overrun set, no state change.
- Sticky flags are cleared only by reset.
- Operand registers keep their values after a job; the next job overwrites them in order.

Test Plan:
- N=32; load mod=0x21, exp=0x07, base=0x02; core model returns 0x1D after 100 cycles → core_start 2 cycles after the third in_valid with the operands on the bus; out_valid with out_word=0x1D 1 cycle after core_done; busy drops after out_busy falls.
- Mod=0x00000000, exp=0x05, base=0x03 → core_start never pulses; bad_mod=1; out_valid with out_word=0x00000000.
- TO_W=4, core never asserts done → timeout=1 at cycle 15 of WAIT_CORE; out_word=0xFFFFFFFF sent; the next job completes normally with timeout still 1.
- Extra in_valid (0xDEADBEEF) during WAIT_CORE → overrun=1; operands unchanged; the result for the original job is correct.
- Reset pulsed in WAIT_CORE, then core_done arrives → no out_valid; state LOAD_MOD; a fresh 3-word job completes normally.
- core_done and watchdog expiry in the same cycle (TO_W=4, done at cycle 15) → out_word=core_result, timeout stays 0.
